// File: rtl/uart_tx_fifo_drain.sv
// UART transmitter: pops bytes from the TX FIFO and sends start/data(LSB first)/[parity]/stop frames on tx.
// Define UART_TX_PARITY_EN to insert an even-parity bit after the MSB.
module uart_tx_fifo_drain #(
   parameter int CLK_FREQ  = 25_000_000,
   parameter int BAUD_RATE = 115_200,
   parameter int WIDTH     = 8
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             tx_enable,
   input  logic             two_stop,
   input  logic             fifo_empty,
   input  logic [WIDTH-1:0] fifo_read_data,
   output logic             fifo_read,
   output logic             tx,
   output logic             busy
);

   localparam int BIT_CYCLES = CLK_FREQ / BAUD_RATE;
   localparam int CNT_W      = (BIT_CYCLES > 1) ? $clog2(BIT_CYCLES) : 1;
   localparam int IDX_W      = $clog2(WIDTH) + 1;

   generate
      if (BIT_CYCLES < 2) begin : g_bad_baud
         $error("uart_tx_fifo_drain: CLK_FREQ / BAUD_RATE must be at least 2");
      end
   endgenerate

   typedef enum logic [2:0] {
      IDLE,
      START,
      DATA,
`ifdef UART_TX_PARITY_EN
      PARITY,
`endif
      STOP
   } state_t;

   state_t           state;
   logic [CNT_W-1:0] cnt;
   logic [IDX_W-1:0] idx;
   logic [WIDTH-1:0] shift;
   logic             stop2;
   logic             bit_end;
`ifdef UART_TX_PARITY_EN
   logic             parity_bit;
`endif

   // The pop strobe is the only combinational output; reset blocks it so nothing is popped while held.
   assign fifo_read = (state == IDLE) && tx_enable && !fifo_empty && !reset;
   assign bit_end   = (cnt == CNT_W'(BIT_CYCLES - 1));

   always_ff @(posedge clk) begin
      if (reset) begin
         state <= IDLE;
         cnt   <= '0;
         idx   <= '0;
         shift <= '0;
         stop2 <= 1'b0;
         tx    <= 1'b1;
         busy  <= 1'b0;
`ifdef UART_TX_PARITY_EN
         parity_bit <= 1'b0;
`endif
      end else begin
         case (state)
            IDLE: begin
               if (fifo_read) begin
                  shift <= fifo_read_data;
                  stop2 <= two_stop;
`ifdef UART_TX_PARITY_EN
                  parity_bit <= ^fifo_read_data;
`endif
                  cnt   <= '0;
                  idx   <= '0;
                  tx    <= 1'b0;
                  busy  <= 1'b1;
                  state <= START;
               end
            end
            START: begin
               if (bit_end) begin
                  cnt   <= '0;
                  tx    <= shift[0];
                  state <= DATA;
               end else begin
                  cnt <= cnt + CNT_W'(1);
               end
            end
            DATA: begin
               if (bit_end) begin
                  cnt   <= '0;
                  shift <= shift >> 1;
                  if (idx == IDX_W'(WIDTH - 1)) begin
                     idx <= '0;
`ifdef UART_TX_PARITY_EN
                     tx    <= parity_bit;
                     state <= PARITY;
`else
                     tx    <= 1'b1;
                     state <= STOP;
`endif
                  end else begin
                     idx <= idx + IDX_W'(1);
                     tx  <= shift[1];
                  end
               end else begin
                  cnt <= cnt + CNT_W'(1);
               end
            end
`ifdef UART_TX_PARITY_EN
            PARITY: begin
               if (bit_end) begin
                  cnt   <= '0;
                  tx    <= 1'b1;
                  state <= STOP;
               end else begin
                  cnt <= cnt + CNT_W'(1);
               end
            end
`endif
            STOP: begin
               // idx counts stop bits here; a second one only when two_stop was latched.
               if (bit_end) begin
                  cnt <= '0;
                  if (stop2 && idx == '0) begin
                     idx <= IDX_W'(1);
                  end else begin
                     idx   <= '0;
                     tx    <= 1'b1;
                     busy  <= 1'b0;
                     state <= IDLE;
                  end
               end else begin
                  cnt <= cnt + CNT_W'(1);
               end
            end
            default: begin
               state <= IDLE;
               tx    <= 1'b1;
               busy  <= 1'b0;
            end
         endcase
      end
   end

endmodule

// File: doc/uart_tx_fifo_drain.md
# uart_tx_fifo_drain

Serial UART transmitter that drains the peripheral TX FIFO and emits 8N1-style frames on `tx`. Sits on the read side of the TX FIFO inside the UART peripheral: the CPU bus writes bytes into the FIFO, this block pops them one at a time and serializes them LSB first at a fixed baud rate derived from the system clock. The FIFO presents its head word combinationally on `read_data` whenever it is not empty, and advances its read pointer on the clock edge where `read` is high.

## Interface
- `CLK_FREQ`, default 25_000_000: system clock frequency in Hz.
- `BAUD_RATE`, default 115_200: line rate in bit/s.
- `WIDTH`, default 8: data bits per frame; must match the FIFO word width.
- `BIT_CYCLES`, derived local, equal to CLK_FREQ / BAUD_RATE (integer division): clock cycles per bit. It must be at least 2, and elaboration fails otherwise.
- `clk`  input  1  system clock, all logic on its rising edge.
- `reset`  input  1  synchronous, active-high reset; clock is `clk`.
- `tx_enable`  input  1  permits starting new frames; a frame in progress always completes.
- `two_stop`  input  1  0 = one stop bit, 1 = two stop bits. Sampled at frame start.
- `fifo_empty`  input  1  FIFO empty flag.
- `fifo_read_data`  input  WIDTH  FIFO head word, valid while `fifo_empty` = 0.
- `fifo_read`  output  1  single-cycle pop strobe to the FIFO.
- `tx`  output  1  serial line, idle high.
- `busy`  output  1  high while a frame is being transmitted.

## Operation
- States: IDLE, START, DATA, PARITY (only when the parity macro is defined), STOP.
- IDLE: `tx` = 1 and `busy` = 0.
  - If `tx_enable` = 1 and `fifo_empty` = 0, assert `fifo_read` for this one cycle.
  - In the same cycle, latch `fifo_read_data` into the shift register and latch `two_stop`.
  - Then go to START.
- START: drive `tx` = 0 for BIT_CYCLES cycles, then go to DATA with bit index 0.
- DATA: drive `tx` = shift[0] for BIT_CYCLES cycles, shift right, and increment the index. After bit WIDTH-1, go to PARITY if the macro is defined, else to STOP.
- PARITY: drive the parity bit for BIT_CYCLES cycles, then go to STOP.
- STOP: drive `tx` = 1 for BIT_CYCLES cycles, or 2×BIT_CYCLES when the latched `two_stop` = 1, then go to IDLE.
- The bit counter runs from 0 to BIT_CYCLES-1 and is $clog2(BIT_CYCLES) bits wide. The bit index is $clog2(WIDTH)+1 bits wide.
- `fifo_read` is never asserted outside IDLE, and never while `fifo_empty` = 1.
- A change of `two_stop` mid-frame has no effect on the current frame.
- Deasserting `tx_enable` mid-frame has no effect on the current frame. No new pop occurs until it returns high.
- Reset mid-frame aborts the frame: `tx` returns high on the next cycle and the popped byte is discarded (not re-queued).

## Timing
- Reset values: `tx` = 1, `fifo_read` = 0, `busy` = 0, state IDLE, all counters 0.
- Cycle N is IDLE with a pop (`fifo_read` = 1).
  - Cycle N+1: `tx` falls and `busy` rises.
  - `tx` returns to IDLE level after F = BIT_CYCLES × (1 + WIDTH + P + S) cycles, where P is 1 if parity is compiled in, else 0, and S is 1 or 2 stop bits.
- Back-to-back frames: exactly one IDLE cycle (`tx` = 1, `busy` = 0, `fifo_read` = 1) separates the last stop cycle of one frame from the start bit of the next. Frame period = F + 1 cycles.
- `fifo_empty` falls while in IDLE: `fifo_read` is asserted in that same cycle. This is a combinational path from `fifo_empty` to `fifo_read`.
- All other outputs are registered.

## Configuration
- `UART_TX_PARITY_EN` defined:
  - PARITY state compiled in.
  - The parity bit is even parity: the XOR of the WIDTH data bits.
  - It is sent after the MSB and before the stop bit(s).
- `UART_TX_PARITY_EN` undefined: no parity bit, no PARITY state, and frames are start + WIDTH data + stop.

## Test plan
All scenarios use CLK_FREQ=40, BAUD_RATE=10 (BIT_CYCLES=4), WIDTH=8, and parity off unless stated.

1. Reset, FIFO empty for 50 cycles -> `tx` = 1, `busy` = 0, and `fifo_read` is never high.
2. FIFO holds 0xA5, `two_stop` = 0 -> one `fifo_read` pulse. `tx` is 0 for 4 cycles, then bits 1,0,1,0,0,1,0,1 at 4 cycles each, then 1 for 4 cycles. `busy` is high for 40 cycles.
3. FIFO holds 0x00, 0xFF, 0x3C back-to-back -> three pops spaced 41 cycles apart, with a single idle-high cycle between frames. The bytes decode correctly.
4. `two_stop` = 1 with 0x55, and `two_stop` toggled mid-frame -> the stop phase lasts 8 cycles. The next frame, started with `two_stop` = 0, has a 4-cycle stop.
5. `tx_enable` dropped during the DATA bits of 0x12 with 0x34 queued -> 0x12 completes. 0x34 is not popped until `tx_enable` returns, and is popped in that same cycle.
6. `reset` asserted in bit 3 of 0x81 -> `tx` = 1 and `busy` = 0 the next cycle, with no further pops until reset releases. With `UART_TX_PARITY_EN`: 0x07 yields parity bit 1 and a frame length of 44 cycles.
